bibp_hakem: RTL and testbench
=============================

# bibp_hakem

Round-robin arbiter and sequencer that shares one combinational `bibp` ALU instance among `ISTEKCI` requesters. Each requester presents a full `bibp` instruction word (`buyruk`) with a valid/ready handshake. The block registers the granted instruction onto the ALU input, captures the ALU result one cycle later, and returns it with the requester's id over a valid/ready response port. It sits between the requester ports and the single shared `bibp`, and contains no arithmetic of its own.

## Interface
- `UZUNLUK`, 8: ALU operand-pair length. Instruction width is `UZUNLUK+3`; result width is `UZUNLUK/2+1`.
- `ISTEKCI`, 4: number of requesters, ≥2. `KW = $clog2(ISTEKCI)`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `istek_gecerli` input ISTEKCI: per-requester valid.
- `istek_buyruk` input ISTEKCI*(UZUNLUK+3): flattened instructions; requester i occupies bits [i*(UZUNLUK+3) +: UZUNLUK+3].
- `istek_hazir` output ISTEKCI: per-requester accept, one-hot or zero.
- `alu_buyruk` output UZUNLUK+3: registered instruction driven to the `bibp.buyruk` input.
- `alu_sonuc` input UZUNLUK/2+1: `bibp.sonuc`.
- `yanit_gecerli` output 1: response valid.
- `yanit_sonuc` output UZUNLUK/2+1: captured ALU result.
- `yanit_kimlik` output KW: index of the requester that owns the response.
- `yanit_hazir` input 1: response consumer ready.
- `tamam_sayisi` output 8: count of completed responses, wraps 255→0.

## Operation
- Three states:
  - BOS: idle, may accept.
  - ISLE: ALU evaluating.
  - YANIT: response held.
- Round-robin pointer `oncelik` (KW bits) names the highest-priority requester. Search order is `oncelik`, `oncelik+1`, … mod ISTEKCI.
- BOS behaviour:
  - If any `istek_gecerli` bit is set, the grant `g` is the first valid requester in search order.
  - `istek_hazir[g]=1` combinationally; all other `istek_hazir` bits are 0.
  - The handshake completes at that rising edge. On the edge: `alu_buyruk <= istek_buyruk[g]`, kimlik register `<= g`, `oncelik <= (g+1) mod ISTEKCI`, state goes to ISLE.
  - If no request is valid, the block stays in BOS and all registers hold.
- ISLE behaviour:
  - `istek_hazir` is all 0.
  - On the edge: `yanit_sonuc <= alu_sonuc`, state goes to YANIT.
- YANIT behaviour:
  - `yanit_gecerli=1`; `yanit_sonuc` and `yanit_kimlik` are stable.
  - If `yanit_hazir=1` at the edge: the response is consumed, `tamam_sayisi` increments, state goes to BOS.
  - Otherwise the block stays in YANIT with outputs held. The stall is unbounded.
- `istek_hazir` is 0 in ISLE and YANIT. No new instruction is accepted until BOS is re-entered.
- Requesters must hold `istek_buyruk` stable while `istek_gecerli=1` and not yet accepted. A requester dropping valid before acceptance is legal and is simply not granted.
- `alu_buyruk` keeps its last value after use. It is not cleared on return to BOS.
- Result width equals the `bibp` result width. No truncation or extension takes place.
- `ISTEKCI` not a power of two: the pointer wraps from ISTEKCI-1 to 0 explicitly.

## Timing
- Reset values (async assert, applied immediately):
  - state = BOS.
  - `oncelik=0`, `alu_buyruk=0`, `yanit_sonuc=0`, `yanit_kimlik=0`, `tamam_sayisi=0`.
  - `yanit_gecerli=0`, `istek_hazir=0`.
- Reset deassertion is synchronised externally. The first acceptance can occur at the first rising edge after deassertion.
- Latency:
  - Accept at edge k.
  - `alu_buyruk` valid after edge k.
  - `yanit_gecerli` high after edge k+1.
  - Earliest consume at edge k+2.
  - Next acceptance at edge k+3 at the earliest.
  - Peak throughput is one operation per 3 cycles.
- Reset asserted mid-operation (ISLE or YANIT): the in-flight response is discarded, and no `yanit_gecerli` pulse is produced afterwards for it.
- Simultaneous requests: exactly one grant per acceptance. A continuously requesting set is served in strict rotation, so each requester waits at most ISTEKCI-1 other operations.
- `tamam_sayisi` increments only on the `yanit_gecerli && yanit_hazir` edge.

## Test plan
- Reset, then a single request:
  - Stimulus: requester 2 presents `buyruk=11'h053` (add, a=5, b=3), with `yanit_hazir=1`.
  - Required: `istek_hazir=4'b0100` in the acceptance cycle; `alu_buyruk=11'h053` one cycle later; `yanit_gecerli=1`, `yanit_sonuc=5'd8`, `yanit_kimlik=2` two cycles after acceptance; `tamam_sayisi=1`.
- Contention:
  - Stimulus: all four requesters valid from reset and held.
  - Required: grants in the order 0,1,2,3,0,… with `istek_hazir` pulses exactly 3 cycles apart.
- Backpressure:
  - Stimulus: `yanit_hazir=0` for 5 cycles during YANIT.
  - Required: `yanit_gecerli`, `yanit_sonuc` and `yanit_kimlik` are held constant and `istek_hazir` stays 0. The block consumes on the first cycle with `yanit_hazir=1`, then accepts the next request.
- Pointer skip:
  - Stimulus: `oncelik=1` with only requester 3 valid.
  - Required: grant 3, after which `oncelik=0`.
- Reset mid-op:
  - Stimulus: assert `rst_n=0` while in ISLE.
  - Required: immediately state = BOS, `yanit_gecerli=0`, counter 0; no response appears after release.
- Counter wrap:
  - Stimulus: 256 completed operations.
  - Required: `tamam_sayisi` reads 0 after the 256th consume.

Source files
------------

// File: rtl/bibp_hakem.sv
// bibp_hakem: round-robin arbiter/sequencer sharing one combinational bibp ALU among requesters
module bibp_hakem #(
  parameter int UZUNLUK = 8,
  parameter int ISTEKCI = 4,
  localparam int KW = $clog2(ISTEKCI),
  localparam int BW = UZUNLUK + 3,
  localparam int SW = UZUNLUK / 2 + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ISTEKCI-1:0]    istek_gecerli,
  input  logic [ISTEKCI*BW-1:0] istek_buyruk,
  output logic [ISTEKCI-1:0]    istek_hazir,
  output logic [BW-1:0]         alu_buyruk,
  input  logic [SW-1:0]         alu_sonuc,
  output logic                  yanit_gecerli,
  output logic [SW-1:0]         yanit_sonuc,
  output logic [KW-1:0]         yanit_kimlik,
  input  logic                  yanit_hazir,
  output logic [7:0]            tamam_sayisi
);
  typedef enum logic [1:0] {BOS, ISLE, YANIT} durum_t;
  durum_t st, st_n;
  logic [KW-1:0] oncelik, kimlik, g, c;
  logic bulundu, kabul;
  // scan from lowest priority upward so the last hit is the highest-priority requester
  always_comb begin
    g = '0;
    c = '0;
    bulundu = 1'b0;
    for (int k = ISTEKCI - 1; k >= 0; k--) begin
      c = KW'((int'(oncelik) + k) % ISTEKCI);
      if (istek_gecerli[c]) begin
        g = c;
        bulundu = 1'b1;
      end
    end
  end
  assign kabul = (st == BOS) && bulundu;
  always_comb begin
    st_n = st;
    st_n = (st == BOS) ? (bulundu ? ISLE : BOS) :
           (st == ISLE) ? YANIT : (yanit_hazir ? BOS : YANIT);
  end
  assign istek_hazir   = kabul ? ({{(ISTEKCI-1){1'b0}}, 1'b1} << g) : '0;
  assign yanit_gecerli = (st == YANIT);
  assign yanit_kimlik  = kimlik;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= BOS;
      oncelik      <= '0;
      alu_buyruk   <= '0;
      yanit_sonuc  <= '0;
      kimlik       <= '0;
      tamam_sayisi <= '0;
    end else begin
      st <= st_n;
      if (kabul) begin
        alu_buyruk <= istek_buyruk[g*BW +: BW];
        kimlik     <= g;
        oncelik    <= (g == KW'(ISTEKCI - 1)) ? '0 : g + 1'b1;
      end
      if (st == ISLE) yanit_sonuc <= alu_sonuc;
      if (st == YANIT && yanit_hazir) tamam_sayisi <= tamam_sayisi + 8'd1;
    end
  end
endmodule

// File: tb/tb_bibp_hakem.sv
// tb_bibp_hakem: directed checks of arbitration, latency, backpressure, reset and counter wrap
module tb_bibp_hakem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  istek_gecerli = '0;
  logic [43:0] istek_buyruk = '0;
  logic [3:0]  istek_hazir;
  logic [10:0] alu_buyruk;
  logic [4:0]  alu_sonuc;
  logic        yanit_gecerli;
  logic [4:0]  yanit_sonuc;
  logic [1:0]  yanit_kimlik;
  logic        yanit_hazir = 1'b0;
  logic [7:0]  tamam_sayisi;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // stand-in ALU: only the add opcode is exercised
  assign alu_sonuc = {1'b0, alu_buyruk[7:4]} + {1'b0, alu_buyruk[3:0]};

  bibp_hakem dut (
    .clk(clk), .rst_n(rst_n), .istek_gecerli(istek_gecerli), .istek_buyruk(istek_buyruk),
    .istek_hazir(istek_hazir), .alu_buyruk(alu_buyruk), .alu_sonuc(alu_sonuc),
    .yanit_gecerli(yanit_gecerli), .yanit_sonuc(yanit_sonuc), .yanit_kimlik(yanit_kimlik),
    .yanit_hazir(yanit_hazir), .tamam_sayisi(tamam_sayisi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] ins(input int r);
    ins = {3'b000, 4'(r + 1), 4'(r)};
  endfunction

  initial begin
    #1;
    chk("rst_hazir", istek_hazir, 0);
    chk("rst_gecerli", yanit_gecerli, 0);
    chk("rst_tamam", tamam_sayisi, 0);
    chk("rst_alu", alu_buyruk, 0);
    chk("rst_sonuc", yanit_sonuc, 0);
    chk("rst_kimlik", yanit_kimlik, 0);
    step();
    rst_n = 1'b1;
    // single request from requester 2: 5 + 3
    istek_buyruk[22 +: 11] = 11'h053;
    istek_gecerli = 4'b0100;
    yanit_hazir = 1'b1;
    #1;
    chk("single_hazir", istek_hazir, 4'b0100);
    step();
    istek_gecerli = '0;
    chk("single_alu", alu_buyruk, 11'h053);
    chk("single_isle_hazir", istek_hazir, 0);
    chk("single_isle_gecerli", yanit_gecerli, 0);
    step();
    chk("single_gecerli", yanit_gecerli, 1);
    chk("single_sonuc", yanit_sonuc, 5'd8);
    chk("single_kimlik", yanit_kimlik, 2);
    step();
    chk("single_tamam", tamam_sayisi, 1);
    chk("single_done", yanit_gecerli, 0);
    // contention: all four valid from reset
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) istek_buyruk[r*11 +: 11] = ins(r);
    istek_gecerli = 4'b1111;
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("cont_grant", istek_hazir, 4'b0001 << (j % 4));
      step();
      chk("cont_alu", alu_buyruk, ins(j % 4));
      chk("cont_gap1", istek_hazir, 0);
      step();
      chk("cont_gap2", istek_hazir, 0);
      chk("cont_kimlik", yanit_kimlik, j % 4);
      chk("cont_sonuc", yanit_sonuc, 2 * (j % 4) + 1);
      step();
    end
    chk("cont_tamam", tamam_sayisi, 8);
    // backpressure on a response from requester 0
    yanit_hazir = 1'b0;
    chk("bp_grant", istek_hazir, 4'b0001);
    step();
    step();
    chk("bp_gecerli0", yanit_gecerli, 1);
    for (int j = 0; j < 5; j++) begin
      step();
      chk("bp_gecerli", yanit_gecerli, 1);
      chk("bp_kimlik", yanit_kimlik, 0);
      chk("bp_sonuc", yanit_sonuc, 5'd1);
      chk("bp_hazir", istek_hazir, 0);
    end
    yanit_hazir = 1'b1;
    step();
    chk("bp_consumed", yanit_gecerli, 0);
    chk("bp_tamam", tamam_sayisi, 9);
    chk("bp_next_grant", istek_hazir, 4'b0010);
    // pointer now 1, only requester 3 valid
    istek_gecerli = 4'b1000;
    #1;
    chk("skip_grant", istek_hazir, 4'b1000);
    step();
    istek_gecerli = '0;
    chk("skip_alu", alu_buyruk, 11'h043);
    step();
    chk("skip_kimlik", yanit_kimlik, 3);
    chk("skip_sonuc", yanit_sonuc, 5'd7);
    step();
    istek_gecerli = 4'b1001;
    #1;
    chk("skip_wrap_grant", istek_hazir, 4'b0001);
    step();
    istek_gecerli = '0;
    step();
    chk("skip_wrap_kimlik", yanit_kimlik, 0);
    step();
    chk("skip_tamam", tamam_sayisi, 11);
    // reset while in ISLE
    istek_gecerli = 4'b0100;
    step();
    istek_gecerli = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_gecerli", yanit_gecerli, 0);
    chk("mid_tamam", tamam_sayisi, 0);
    chk("mid_sonuc", yanit_sonuc, 0);
    chk("mid_kimlik", yanit_kimlik, 0);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("mid_no_resp", yanit_gecerli, 0);
    end
    istek_gecerli = 4'b0010;
    #1;
    chk("mid_bos_grant", istek_hazir, 4'b0010);
    istek_gecerli = 4'b1111;
    // 256 completed operations wrap the counter
    for (int n = 1; n <= 256; n++) begin
      step();
      step();
      step();
      if (n == 255) chk("wrap_255", tamam_sayisi, 255);
      if (n == 256) chk("wrap_0", tamam_sayisi, 0);
    end
    istek_gecerli = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
